// File: rtl/rx_checker.sv
// RX bit slicer, TX/RX latency search and locked BER counters.
// Define RX_CHECKER_LOL_EN to build windowed loss-of-lock detection.
module rx_checker #(
   parameter int FILTER_OUT_WIDTH = 16,
   parameter int IN_WIDTH         = FILTER_OUT_WIDTH,
   parameter int THRESH           = 0,
   parameter int MAX_LAT          = 16,
   parameter int LAT_WIDTH        = $clog2(MAX_LAT),
   parameter int LOCK_LEN         = 32,
   parameter int CNT_WIDTH        = 32,
   parameter int LOL_WINDOW       = 64,
   parameter int LOL_ERRS         = 8
) (
   input  logic                       clk_sys,
   input  logic                       rst_n,
   input  logic signed [IN_WIDTH-1:0] in,
   input  logic                       sample_en,
   input  logic                       tx_bit,
   input  logic                       tx_valid,
   input  logic                       clear_cnt,
   output logic                       rx_bit,
   output logic                       rx_valid,
   output logic                       locked,
   output logic [LAT_WIDTH-1:0]       latency,
   output logic [CNT_WIDTH-1:0]       bit_count,
   output logic [CNT_WIDTH-1:0]       err_count,
   output logic                       lol
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SEARCH = 2'd1;
   localparam logic [1:0] LOCKED = 2'd2;

   localparam int WU_W = $clog2(MAX_LAT + 1);
   localparam int MC_W = $clog2(LOCK_LEN + 1);

   localparam logic signed [IN_WIDTH-1:0] THRESH_V = IN_WIDTH'(THRESH);
   localparam logic [LAT_WIDTH-1:0] LAT_LAST = LAT_WIDTH'(MAX_LAT - 1);
   localparam logic [WU_W-1:0]      WU_LAST  = WU_W'(MAX_LAT - 1);
   localparam logic [MC_W-1:0]      MC_LAST  = MC_W'(LOCK_LEN - 1);

   if (MAX_LAT < 2 || LOCK_LEN < 1 || LOL_WINDOW < 1 || LOL_ERRS < 1) begin : g_bad_cfg
      $error("rx_checker: invalid parameter set");
   end

   logic [1:0]           state;
   logic [MAX_LAT-1:0]   tx_hist;
   logic [WU_W-1:0]      wu_cnt;
   logic [MC_W-1:0]      match_cnt;
   logic                 slice;
   logic                 exp_bit;
   logic                 match;
   logic                 cnt_full;
   logic                 lol_hit;
   logic [LAT_WIDTH-1:0] lat_next;

   // Expected bit reads the pre-shift history on coincident tx_valid.
   assign slice    = (in >= THRESH_V);
   assign exp_bit  = tx_hist[latency];
   assign match    = (slice == exp_bit);
   assign cnt_full = &bit_count;
   assign lat_next = (latency == LAT_LAST) ? '0 : latency + LAT_WIDTH'(1);

`ifdef RX_CHECKER_LOL_EN
   localparam int WC_W = $clog2(LOL_WINDOW + 1);
   localparam int WE_W = $clog2(LOL_ERRS + 1);
   localparam logic [WC_W-1:0] WC_LAST = WC_W'(LOL_WINDOW - 1);

   logic [WC_W-1:0] win_cnt;
   logic [WE_W-1:0] win_err;
   logic [WE_W-1:0] win_err_nx;

   assign win_err_nx = win_err + WE_W'(!match);
   assign lol_hit    = (state == LOCKED) && sample_en &&
                       (win_err_nx == WE_W'(LOL_ERRS));

   always_ff @(posedge clk_sys) begin
      if (!rst_n || state != LOCKED) begin
         win_cnt <= '0;
         win_err <= '0;
      end else if (sample_en) begin
         if (lol_hit || win_cnt == WC_LAST) begin
            win_cnt <= '0;
            win_err <= '0;
         end else begin
            win_cnt <= win_cnt + WC_W'(1);
            win_err <= win_err_nx;
         end
      end
   end

   always_ff @(posedge clk_sys) begin
      if (!rst_n)
         lol <= 1'b0;
      else if (lol_hit)
         lol <= 1'b1;
      else if (clear_cnt)
         lol <= 1'b0;
   end
`else
   assign lol_hit = 1'b0;
   assign lol     = 1'b0;
`endif

   always_ff @(posedge clk_sys) begin
      if (!rst_n) begin
         state     <= IDLE;
         tx_hist   <= '0;
         wu_cnt    <= '0;
         match_cnt <= '0;
         rx_bit    <= 1'b0;
         rx_valid  <= 1'b0;
         locked    <= 1'b0;
         latency   <= '0;
         bit_count <= '0;
         err_count <= '0;
      end else begin
         rx_valid <= sample_en;
         if (sample_en)
            rx_bit <= slice;
         if (tx_valid)
            tx_hist <= {tx_hist[MAX_LAT-2:0], tx_bit};
         case (state)
            IDLE: begin
               if (tx_valid) begin
                  if (wu_cnt == WU_LAST) begin
                     state     <= SEARCH;
                     wu_cnt    <= '0;
                     latency   <= '0;
                     match_cnt <= '0;
                  end else begin
                     wu_cnt <= wu_cnt + WU_W'(1);
                  end
               end
            end
            SEARCH: begin
               if (sample_en) begin
                  if (!match) begin
                     match_cnt <= '0;
                     latency   <= lat_next;
                  end else if (match_cnt == MC_LAST) begin
                     state     <= LOCKED;
                     locked    <= 1'b1;
                     match_cnt <= '0;
                     bit_count <= '0;
                     err_count <= '0;
                  end else begin
                     match_cnt <= match_cnt + MC_W'(1);
                  end
               end
            end
            LOCKED: begin
               if (sample_en && !cnt_full) begin
                  bit_count <= bit_count + CNT_WIDTH'(1);
                  if (!match)
                     err_count <= err_count + CNT_WIDTH'(1);
               end
               if (lol_hit) begin
                  state     <= SEARCH;
                  locked    <= 1'b0;
                  latency   <= lat_next;
                  match_cnt <= '0;
               end
            end
            default: state <= IDLE;
         endcase
         // Clear overrides any count made on the same sample.
         if (clear_cnt) begin
            bit_count <= '0;
            err_count <= '0;
         end
      end
   end

endmodule

// File: tb/tb_rx_checker.sv
// Directed bench for rx_checker: reset, slicer edge, search wrap,
// loopback lock, error injection, clear, counter saturation.
module tb_rx_checker;

   logic clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   logic               rst_n;
   logic signed [15:0] in;
   logic               sample_en;
   logic               tx_bit;
   logic               tx_valid;
   logic               clear_cnt;

   logic        rx_bit, rx_valid, locked, lol;
   logic [3:0]  latency;
   logic [31:0] bit_count, err_count;

   logic        s_rx_bit, s_rx_valid, s_locked, s_lol;
   logic [3:0]  s_latency;
   logic [3:0]  s_bit_count, s_err_count;

   rx_checker u_dut (
      .clk_sys   (clk_sys),
      .rst_n     (rst_n),
      .in        (in),
      .sample_en (sample_en),
      .tx_bit    (tx_bit),
      .tx_valid  (tx_valid),
      .clear_cnt (clear_cnt),
      .rx_bit    (rx_bit),
      .rx_valid  (rx_valid),
      .locked    (locked),
      .latency   (latency),
      .bit_count (bit_count),
      .err_count (err_count),
      .lol       (lol)
   );

   rx_checker #(.CNT_WIDTH(4)) u_sat (
      .clk_sys   (clk_sys),
      .rst_n     (rst_n),
      .in        (in),
      .sample_en (sample_en),
      .tx_bit    (tx_bit),
      .tx_valid  (tx_valid),
      .clear_cnt (clear_cnt),
      .rx_bit    (s_rx_bit),
      .rx_valid  (s_rx_valid),
      .locked    (s_locked),
      .latency   (s_latency),
      .bit_count (s_bit_count),
      .err_count (s_err_count),
      .lol       (s_lol)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [6:0]  prbs  = 7'h7F;
   logic [63:0] tx_sr = '0;
   logic [31:0] xs    = 32'h2545_F491;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   // One TX bit then one RX sample on the next cycle.
   // mode 0: RX = TX delayed 5, 1: inverted, 2: uncorrelated
   task automatic period(input int mode, input logic clr);
      logic b;
      logic r;
      b      = prbs[6] ^ prbs[5];
      prbs   = {prbs[5:0], b};
      tx_sr  = {tx_sr[62:0], b};
      tx_valid  = 1'b1;
      tx_bit    = b;
      sample_en = 1'b0;
      step();
      tx_valid = 1'b0;
      xs = xs ^ (xs << 13);
      xs = xs ^ (xs >> 17);
      xs = xs ^ (xs << 5);
      case (mode)
         0:       r = tx_sr[5];
         1:       r = ~tx_sr[5];
         default: r = xs[0];
      endcase
      in        = r ? 16'sd1000 : -16'sd1000;
      sample_en = 1'b1;
      clear_cnt = clr;
      step();
      sample_en = 1'b0;
      clear_cnt = 1'b0;
   endtask

   initial begin
      int         k;
      int         wraps;
      int         bad_step;
      logic       ever_locked;
      logic [3:0] prev;

      rst_n     = 1'b0;
      in        = '0;
      sample_en = 1'b0;
      tx_bit    = 1'b0;
      tx_valid  = 1'b0;
      clear_cnt = 1'b0;

      repeat (3) begin
         tx_valid  = 1'($urandom_range(0, 1));
         tx_bit    = 1'($urandom_range(0, 1));
         sample_en = 1'($urandom_range(0, 1));
         in        = 16'($urandom);
         step();
      end
      tx_valid  = 1'b0;
      sample_en = 1'b0;
      chk("rst_rx_valid", rx_valid, 0);
      chk("rst_rx_bit", rx_bit, 0);
      chk("rst_locked", locked, 0);
      chk("rst_latency", latency, 0);
      chk("rst_bit_count", bit_count, 0);
      chk("rst_err_count", err_count, 0);
      chk("rst_lol", lol, 0);
      rst_n = 1'b1;

      in = 16'sd0;
      sample_en = 1'b1;
      step();
      sample_en = 1'b0;
      chk("thr_equal", rx_bit, 1);
      chk("rx_valid_pulse", rx_valid, 1);
      in = -16'sd1;
      sample_en = 1'b1;
      step();
      sample_en = 1'b0;
      chk("thr_below", rx_bit, 0);
      step();
      chk("rx_valid_low", rx_valid, 0);
      chk("rx_bit_hold", rx_bit, 0);
      chk("idle_no_count", bit_count, 0);

      ever_locked = 1'b0;
      wraps    = 0;
      bad_step = 0;
      prev     = latency;
      for (int i = 0; i < 2000; i++) begin
         period(2, 1'b0);
         if (i == 14)
            chk("warmup_unlocked", locked, 0);
         if (locked)
            ever_locked = 1'b1;
         if (latency != prev && latency != prev + 4'd1)
            bad_step++;
         if (prev == 4'd15 && latency == 4'd0)
            wraps++;
         prev = latency;
      end
      chk("random_no_lock", ever_locked, 0);
      chk("lat_wrap_seen", wraps > 0, 1);
      chk("lat_step", bad_step, 0);

      k = 0;
      while (!locked && k < 400) begin
         period(0, 1'b0);
         k++;
      end
      chk("lock_reached", locked, 1);
      chk("lock_latency", latency, 5);
      chk("lock_bits", bit_count, 0);
      chk("lock_errs", err_count, 0);
      chk("sat_lock", s_locked, 1);

      repeat (20) period(0, 1'b0);
      chk("loop_bits", bit_count, 20);
      chk("loop_errs", err_count, 0);

      period(1, 1'b0);
      chk("inj_errs", err_count, 1);
      chk("inj_bits", bit_count, 21);

      period(0, 1'b1);
      chk("clr_bits", bit_count, 0);
      chk("clr_errs", err_count, 0);
      chk("clr_locked", locked, 1);

      for (int i = 0; i < 40; i++)
         period((i == 1 || i == 4 || i == 7) ? 1 : 0, 1'b0);
      chk("run40_bits", bit_count, 40);
      chk("run40_errs", err_count, 3);
      chk("sat_bits", s_bit_count, 15);
      chk("sat_errs", s_err_count, 3);

      period(1, 1'b0);
      chk("sat_frozen_bits", s_bit_count, 15);
      chk("sat_frozen_errs", s_err_count, 3);
      chk("post_sat_errs", err_count, 4);

`ifdef RX_CHECKER_LOL_EN
      k = 0;
      while (!lol && k < 200) begin
         period(1, 1'b0);
         k++;
      end
      chk("lol_set", lol, 1);
      chk("lol_unlocked", locked, 0);
      chk("lol_latency", latency, 6);
`else
      repeat (20) period(1, 1'b0);
      chk("inv_errs", err_count, 24);
      chk("inv_bits", bit_count, 61);
      chk("inv_locked", locked, 1);
      chk("inv_lol", lol, 0);
      chk("inv_latency", latency, 5);
`endif

      clear_cnt = 1'b1;
      step();
      clear_cnt = 1'b0;
      chk("clr2_bits", bit_count, 0);
      chk("clr2_errs", err_count, 0);
      chk("clr2_lol", lol, 0);

      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("rst2_locked", locked, 0);
      chk("rst2_latency", latency, 0);
      repeat (10) period(0, 1'b0);
      chk("rewarm_unlocked", locked, 0);
      chk("rewarm_bits", bit_count, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rx_checker.md
Name: rx_checker

Overview:
- Sits directly downstream of the channel filter; consumes its summed output sample (FILTER_OUT_FORMAT).
- Slices each RX sample to a bit and aligns the RX bit stream to the TX bit stream by searching the TX-to-RX latency.
- Once locked, counts compared bits and bit errors for BER reporting.
- Runs on the system emulation clock; samples only on cycles flagged by the RX sampling-time strobe.

Parameters:
- IN_WIDTH, FILTER_OUT_WIDTH: width of the signed filter output sample.
- THRESH, 0: signed slicer threshold in filter-output LSBs; bit = (in >= THRESH).
- MAX_LAT, 16: depth of the TX bit history; latency search range is 0..MAX_LAT-1.
- LAT_WIDTH, $clog2(MAX_LAT): width of the latency output.
- LOCK_LEN, 32: consecutive matches required to declare lock.
- CNT_WIDTH, 32: width of the bit and error counters (saturating).
- LOL_WINDOW, 64: loss-of-lock window length in samples (macro builds only).
- LOL_ERRS, 8: errors within one window that trigger loss of lock (macro builds only).

Ports:
- clk_sys  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- in  in  IN_WIDTH  signed filter output, treated as FILTER_OUT_FORMAT.
- sample_en  in  1  RX sampling strobe; `in` is valid on this cycle.
- tx_bit  in  1  transmitted bit.
- tx_valid  in  1  tx_bit is valid this cycle; shifts the TX history.
- clear_cnt  in  1  synchronous clear of the bit and error counters.
- rx_bit  out  1  sliced bit, registered.
- rx_valid  out  1  one-cycle pulse, registered copy of sample_en.
- locked  out  1  high while in state LOCKED.
- latency  out  LAT_WIDTH  current candidate or locked latency, in TX bits.
- bit_count  out  CNT_WIDTH  bits compared while locked.
- err_count  out  CNT_WIDTH  mismatches while locked.
- lol  out  1  sticky loss-of-lock flag.

Behaviour:
- Reset: when rst_n=0 on a clock edge, all outputs go to 0, the state goes to IDLE, and tx_hist, match_cnt and the warmup counter are cleared.
- TX history:
  - On tx_valid, tx_hist shifts by one and tx_bit enters at index 0.
  - The expected bit is tx_hist[latency], using the pre-shift value when tx_valid and sample_en coincide.
- Slicer: on sample_en, rx_bit <= (in >= THRESH) as a signed compare, and rx_valid <= 1. Otherwise rx_valid <= 0 and rx_bit holds. Latency is 1 cycle.
- The match/compare for a sample happens in the same cycle as the rx_bit update, using the combinational slice.
- State IDLE:
  - Count tx_valid pulses; after MAX_LAT of them, go to SEARCH with latency=0 and match_cnt=0.
  - Samples arriving in IDLE are sliced but not compared.
- State SEARCH, on each sample_en:
  - Match: match_cnt++.
  - Mismatch: match_cnt=0 and latency++, wrapping from MAX_LAT-1 to 0.
  - When match_cnt reaches LOCK_LEN: go to LOCKED, set locked=1, and zero both counters. The locking sample is not counted.
- State LOCKED, on each sample_en:
  - bit_count++.
  - err_count++ on mismatch.
  - When bit_count equals all-ones, both counters freeze. err_count never exceeds bit_count.
- clear_cnt:
  - Zeroes both counters in any state; lock status is unchanged.
  - If clear_cnt and sample_en coincide, clear wins and the sample is not counted.
  - clear_cnt also clears lol.
- Reset mid-LOCKED returns to IDLE and requires full re-warmup.
- Without the optional macro, LOCKED exits only on reset, and lol is held at 0.

Optional Feature:
- Macro: RX_CHECKER_LOL_EN.
- When defined, LOCKED runs windows of LOL_WINDOW samples with a window error count.
  - If the window error count reaches LOL_ERRS within a window: set lol=1 (sticky until clear_cnt or reset), go to SEARCH at latency+1 (wrapping), match_cnt=0, locked=0.
  - Counters hold their values.
  - The window error count resets at the end of each window.
- When undefined: no window logic is built; lol is tied to 0.

Test Plan:
- Reset: hold rst_n=0 for 3 clocks with random in/tx activity -> all outputs 0, no rx_valid. Release -> locked=0 until 16 tx_valid pulses plus the search completes.
- Loopback: TX PRBS7, with in = +1000 for a 1 and -1000 for a 0, delayed 5 bits; one sample per tx_valid -> locked=1, latency=5, err_count=0, bit_count increments by 1 per sample.
- Error injection: after lock, invert the slice of one sample -> err_count=1. Then assert clear_cnt together with sample_en -> both counters 0 and the sample is not counted.
- Saturation: CNT_WIDTH=4, 40 locked samples with 3 errors in the first 10 -> bit_count=15, err_count=3, frozen.
- Search wrap: RX driven with an uncorrelated PRBS for 2000 samples -> locked stays 0, latency cycles 0..15 and wraps to 0. Edge case in = THRESH exactly -> rx_bit=1.
- RX_CHECKER_LOL_EN defined, LOL_WINDOW=64, LOL_ERRS=8: lock at latency 5, then invert all RX bits -> after the 8th error lol=1, locked=0, search restarts at latency 6. Without the macro, the same stimulus gives err_count rising, locked staying 1, lol=0.
